// File: rtl/floo_atop_id_allocator_pkg.sv
// Shared types and helpers for the atomic-transaction ID allocator.
// Contents: per-slot state encoding, the next-state result struct, the ID width
// helper, and the slot transition function used by floo_atop_slot.
package floo_atop_id_allocator_pkg;

  // Lifecycle of one atomic ID slot.
  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_WAIT_BR = 2'd1,
    SLOT_WAIT_B  = 2'd2,
    SLOT_WAIT_R  = 2'd3
  } atop_slot_state_e;

  typedef struct packed {
    atop_slot_state_e state;
    logic             illegal;
  } slot_next_t;

  // Width of an index into a pool of n entries; at least one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Slot transition. A completion that the current state does not expect is
  // flagged and otherwise ignored; an expected completion arriving alongside
  // it still takes effect.
  function automatic slot_next_t next_slot_state(input atop_slot_state_e state,
                                                 input logic commit,
                                                 input logic need_r,
                                                 input logic b,
                                                 input logic r);
    slot_next_t res;
    res.state   = state;
    res.illegal = 1'b0;
    unique case (state)
      SLOT_FREE: begin
        res.illegal = b | r;
        if (commit) res.state = need_r ? SLOT_WAIT_BR : SLOT_WAIT_B;
      end
      SLOT_WAIT_BR: begin
        if (b && r)  res.state = SLOT_FREE;
        else if (b)  res.state = SLOT_WAIT_R;
        else if (r)  res.state = SLOT_WAIT_B;
      end
      SLOT_WAIT_B: begin
        res.illegal = r;
        if (b) res.state = SLOT_FREE;
      end
      SLOT_WAIT_R: begin
        res.illegal = b;
        if (r) res.state = SLOT_FREE;
      end
      default: res.state = SLOT_FREE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/floo_atop_slot.sv
// One atomic ID slot: holds its state and reacts to commits and completions
// already decoded for this slot's index.
// Ports: clk, rst_n (async active-low); commit, need_r, b_done, r_done (decoded
// events); free (state is FREE), retire (leaves a WAIT state this cycle),
// err (an unexpected completion hit this slot this cycle).
module floo_atop_slot
  import floo_atop_id_allocator_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic commit,
  input  logic need_r,
  input  logic b_done,
  input  logic r_done,
  output logic free,
  output logic retire,
  output logic err
);

  atop_slot_state_e state_q;
  slot_next_t       nxt;

  always_comb begin
    nxt = next_slot_state(state_q, commit, need_r, b_done, r_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SLOT_FREE;
    else        state_q <= nxt.state;
  end

  assign free   = (state_q == SLOT_FREE);
  assign retire = (state_q != SLOT_FREE) && (nxt.state == SLOT_FREE);
  assign err    = nxt.illegal;

endmodule

// File: rtl/floo_atop_id_allocator.sv
// Allocates unique AXI IDs to atomic AWs and retires them once B (and the last
// R, when expected) have returned.
// Ports: clk_i, rst_ni; alloc_req_i/alloc_need_r_i/alloc_commit_i from the AW
// path; alloc_avail_o/alloc_id_o offer an ID combinationally (zero-cycle grant);
// b_done_i/b_id_i and r_done_i/r_id_i report completions; busy_o is the per-slot
// occupied vector, usage_o the registered occupied count, err_o a one-cycle
// pulse after an unexpected or out-of-range completion.
module floo_atop_id_allocator
  import floo_atop_id_allocator_pkg::*;
#(
  parameter  int unsigned NumIds  = 4,
  localparam int unsigned IdWidth = id_width(NumIds)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               alloc_req_i,
  input  logic               alloc_need_r_i,
  input  logic               alloc_commit_i,
  output logic               alloc_avail_o,
  output logic [IdWidth-1:0] alloc_id_o,
  input  logic               b_done_i,
  input  logic [IdWidth-1:0] b_id_i,
  input  logic               r_done_i,
  input  logic [IdWidth-1:0] r_id_i,
  output logic [NumIds-1:0]  busy_o,
  output logic [IdWidth:0]   usage_o,
  output logic               err_o
);

  localparam int unsigned UsageWidth = IdWidth + 1;

  logic [NumIds-1:0]     free_vec, retire_vec, slot_err;
  logic [NumIds-1:0]     commit_vec, b_hit, r_hit;
  logic                  offer_lock_q;
  logic [IdWidth-1:0]    offer_id_q, lzc_id;
  logic                  grant, b_oor, r_oor;
  logic [UsageWidth-1:0] usage_q, usage_d;
  logic                  err_q;

  // Lowest free slot, from registered state only.
  always_comb begin
    logic found;
    lzc_id = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      if (free_vec[i] && !found) begin
        lzc_id = IdWidth'(i);
        found  = 1'b1;
      end
    end
  end

  // A locked offer stays put until committed, even if a lower slot frees.
  assign alloc_avail_o = offer_lock_q | (|free_vec);
  assign alloc_id_o    = offer_lock_q ? offer_id_q : lzc_id;
  assign grant         = alloc_req_i & alloc_avail_o & alloc_commit_i;

  assign b_oor = b_done_i && (32'(b_id_i) >= NumIds);
  assign r_oor = r_done_i && (32'(r_id_i) >= NumIds);

  for (genvar k = 0; k < NumIds; k++) begin : g_slot
    assign commit_vec[k] = grant    && (alloc_id_o == IdWidth'(k));
    assign b_hit[k]      = b_done_i && (b_id_i == IdWidth'(k));
    assign r_hit[k]      = r_done_i && (r_id_i == IdWidth'(k));

    floo_atop_slot i_slot (
      .clk    (clk_i),
      .rst_n  (rst_ni),
      .commit (commit_vec[k]),
      .need_r (alloc_need_r_i),
      .b_done (b_hit[k]),
      .r_done (r_hit[k]),
      .free   (free_vec[k]),
      .retire (retire_vec[k]),
      .err    (slot_err[k])
    );
  end

  // Offer lock: freeze the offered ID while the AW waits for ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      offer_lock_q <= 1'b0;
      offer_id_q   <= '0;
    end else if (grant) begin
      offer_lock_q <= 1'b0;
    end else if (alloc_req_i && alloc_avail_o) begin
      offer_lock_q <= 1'b1;
      offer_id_q   <= alloc_id_o;
    end
  end

  // Usage: +1 per commit, -1 per slot returning to FREE.
  always_comb begin
    usage_d = usage_q + UsageWidth'(grant);
    for (int unsigned i = 0; i < NumIds; i++) begin
      if (retire_vec[i]) usage_d = usage_d - UsageWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      usage_q <= '0;
      err_q   <= 1'b0;
    end else begin
      usage_q <= usage_d;
      err_q   <= (|slot_err) | b_oor | r_oor;
    end
  end

  assign busy_o  = ~free_vec;
  assign usage_o = usage_q;
  assign err_o   = err_q;

  // Upstream must hold the AW once an ID has been offered to it.
  ap_no_drop : assert property (@(posedge clk_i) disable iff (!rst_ni)
    offer_lock_q |-> alloc_req_i);

  ap_commit_free : assert property (@(posedge clk_i) disable iff (!rst_ni)
    grant |-> free_vec[alloc_id_o]);

  ap_usage_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    usage_q <= UsageWidth'(NumIds));

endmodule

// File: tb/tb_floo_atop_id_allocator.sv
// Self-checking bench for floo_atop_id_allocator (NumIds = 4). A reference model
// predicts the offer and the registered outputs for every driven cycle; the
// predictions are queued at drive time and compared when the DUT shows them.
module tb_floo_atop_id_allocator;

  localparam int unsigned N = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       alloc_req_i, alloc_need_r_i, alloc_commit_i;
  logic       alloc_avail_o;
  logic [1:0] alloc_id_o;
  logic       b_done_i, r_done_i;
  logic [1:0] b_id_i, r_id_i;
  logic [3:0] busy_o;
  logic [2:0] usage_o;
  logic       err_o;

  always #5 clk_i = ~clk_i;

  floo_atop_id_allocator #(.NumIds(N)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .alloc_req_i    (alloc_req_i),
    .alloc_need_r_i (alloc_need_r_i),
    .alloc_commit_i (alloc_commit_i),
    .alloc_avail_o  (alloc_avail_o),
    .alloc_id_o     (alloc_id_o),
    .b_done_i       (b_done_i),
    .b_id_i         (b_id_i),
    .r_done_i       (r_done_i),
    .r_id_i         (r_id_i),
    .busy_o         (busy_o),
    .usage_o        (usage_o),
    .err_o          (err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] exp_c_q[$];   // {avail, id}
  logic [7:0] exp_r_q[$];   // {busy, usage, err}

  // Reference model: 0 free, 1 wait B+R, 2 wait B, 3 wait R.
  int  m_st[N];
  bit  m_lock;
  int  m_lock_id;
  bit  m_err;

  logic       last_avail;
  logic [1:0] last_id;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_st[i] = 0;
    m_lock = 0; m_lock_id = 0; m_err = 0;
  endfunction

  function automatic bit m_avail();
    bit a = m_lock;
    for (int i = 0; i < N; i++) if (m_st[i] == 0) a = 1;
    return a;
  endfunction

  function automatic int m_id();
    if (m_lock) return m_lock_id;
    for (int i = 0; i < N; i++) if (m_st[i] == 0) return i;
    return 0;
  endfunction

  function automatic logic [3:0] m_busy();
    logic [3:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_st[i] != 0);
    return v;
  endfunction

  function automatic logic [2:0] m_usage();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_st[i] != 0) c++;
    return 3'(c);
  endfunction

  // Drive one clock cycle (entered and left on a falling edge); predictions are
  // queued now and checked once the DUT presents them.
  task automatic cycle(input logic req, input logic nr, input logic cm,
                       input logic b, input int bid, input logic r, input int rid);
    bit g;
    int gid;
    bit ill;
    int ns[N];
    logic [2:0] ec;
    logic [7:0] er;
    alloc_req_i    = req;
    alloc_need_r_i = nr;
    alloc_commit_i = cm;
    b_done_i = b; b_id_i = 2'(bid);
    r_done_i = r; r_id_i = 2'(rid);

    exp_c_q.push_back({m_avail(), 2'(m_id())});
    g   = req && m_avail() && cm;
    gid = m_id();
    ill = 0;
    for (int k = 0; k < N; k++) begin
      bit bb, rr;
      bb = b && (bid == k);
      rr = r && (rid == k);
      ns[k] = m_st[k];
      case (m_st[k])
        0: if (bb || rr) ill = 1;
        1: begin
          if (bb && rr) ns[k] = 0;
          else if (bb)  ns[k] = 3;
          else if (rr)  ns[k] = 2;
        end
        2: begin if (rr) ill = 1; if (bb) ns[k] = 0; end
        default: begin if (bb) ill = 1; if (rr) ns[k] = 0; end
      endcase
      if (g && gid == k) ns[k] = nr ? 1 : 2;
    end
    if (g) m_lock = 0;
    else if (req && m_avail()) begin m_lock = 1; m_lock_id = gid; end
    for (int k = 0; k < N; k++) m_st[k] = ns[k];
    m_err = ill;
    exp_r_q.push_back({m_busy(), m_usage(), m_err});

    #1;
    last_avail = alloc_avail_o;
    last_id    = alloc_id_o;
    ec = exp_c_q.pop_front();
    n_vec++;
    if ({alloc_avail_o, alloc_id_o} !== ec) begin
      n_err++;
      $display("FAIL offer @%0t: got avail=%b id=%0d, want avail=%b id=%0d",
               $time, alloc_avail_o, alloc_id_o, ec[2], ec[1:0]);
    end
    @(posedge clk_i);
    #1;
    er = exp_r_q.pop_front();
    n_vec++;
    if ({busy_o, usage_o, err_o} !== er) begin
      n_err++;
      $display("FAIL regs @%0t: got busy=%b usage=%0d err=%b, want busy=%b usage=%0d err=%b",
               $time, busy_o, usage_o, err_o, er[7:4], er[3:1], er[0]);
    end
    @(negedge clk_i);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    n_vec++;
    if ({alloc_avail_o, alloc_id_o, busy_o, usage_o, err_o} !== {1'b1, 2'd0, 4'd0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL %s: got avail=%b id=%0d busy=%b usage=%0d err=%b, want 1 0 0000 0 0",
               tag, alloc_avail_o, alloc_id_o, busy_o, usage_o, err_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    alloc_req_i = 0; alloc_need_r_i = 0; alloc_commit_i = 0;
    b_done_i = 0; b_id_i = 0; r_done_i = 0; r_id_i = 0;
    m_reset();
    #3;
    check_reset_values("reset_values");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 1, 0, 0, 0, 0);
      n_vec++;
      if (last_id !== 2'(i)) begin
        n_err++;
        $display("FAIL fill_id: got %0d, want %0d", last_id, i);
      end
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (last_avail !== 1'b0 || usage_o !== 3'd4) begin
      n_err++;
      $display("FAIL fill_full: got avail=%b usage=%0d, want avail=0 usage=4", last_avail, usage_o);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, i, 0, 0);
  endtask

  task automatic test_offer_stability();
    cycle(1, 0, 1, 0, 0, 0, 0);            // ID 0 busy
    for (int c = 0; c < 3; c++) begin
      cycle(1, 0, 0, (c == 1), 0, 0, 0);   // b_done id0 in the second wait cycle
      n_vec++;
      if (last_id !== 2'd1) begin
        n_err++;
        $display("FAIL offer_hold c%0d: got id=%0d, want 1", c, last_id);
      end
    end
    cycle(1, 0, 1, 0, 0, 0, 0);
    n_vec++;
    if (last_id !== 2'd1) begin
      n_err++;
      $display("FAIL offer_commit: got id=%0d, want 1", last_id);
    end
    cycle(1, 0, 1, 0, 0, 0, 0);
    n_vec++;
    if (last_id !== 2'd0) begin
      n_err++;
      $display("FAIL offer_after_unlock: got id=%0d, want 0", last_id);
    end
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0);
  endtask

  task automatic test_need_r();
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0);            // ID 2 expects R
    cycle(0, 0, 0, 1, 2, 0, 0);
    n_vec++;
    if (busy_o[2] !== 1'b1 || usage_o !== 3'd3) begin
      n_err++;
      $display("FAIL need_r_after_b: got busy2=%b usage=%0d, want 1 3", busy_o[2], usage_o);
    end
    cycle(0, 0, 0, 0, 0, 1, 2);
    n_vec++;
    if (busy_o[2] !== 1'b0 || usage_o !== 3'd2) begin
      n_err++;
      $display("FAIL need_r_after_r: got busy2=%b usage=%0d, want 0 2", busy_o[2], usage_o);
    end
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0);
  endtask

  task automatic test_same_cycle();
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0);            // slot 1 WAIT_BR
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 1, 1, 1);            // commit slot 3, B+R slot 1
    n_vec++;
    if (last_id !== 2'd3 || busy_o !== 4'b1101 || usage_o !== 3'd3) begin
      n_err++;
      $display("FAIL same_cycle: got id=%0d busy=%b usage=%0d, want 3 1101 3",
               last_id, busy_o, usage_o);
    end
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 2, 0, 0);
    cycle(0, 0, 0, 1, 3, 0, 0);
  endtask

  task automatic test_err();
    cycle(0, 0, 0, 1, 3, 0, 0);            // B to a free slot
    n_vec++;
    if (err_o !== 1'b1 || busy_o !== 4'b0000 || usage_o !== 3'd0) begin
      n_err++;
      $display("FAIL err_pulse: got err=%b busy=%b usage=%0d, want 1 0000 0", err_o, busy_o, usage_o);
    end
    idle();
    n_vec++;
    if (err_o !== 1'b0) begin
      n_err++;
      $display("FAIL err_single: got err=%b, want 0", err_o);
    end
    cycle(1, 0, 1, 0, 0, 0, 0);            // slot 0 WAIT_B
    cycle(0, 0, 0, 0, 0, 1, 0);            // R to WAIT_B slot
    n_vec++;
    if (err_o !== 1'b1 || busy_o !== 4'b0001) begin
      n_err++;
      $display("FAIL err_r_on_b: got err=%b busy=%b, want 1 0001", err_o, busy_o);
    end
    cycle(0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_avail_timing();
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);            // slot 0 frees in this cycle
    n_vec++;
    if (last_avail !== 1'b0) begin
      n_err++;
      $display("FAIL avail_same_cycle: got %b, want 0", last_avail);
    end
    idle();
    n_vec++;
    if (last_avail !== 1'b1 || last_id !== 2'd0) begin
      n_err++;
      $display("FAIL avail_next_cycle: got avail=%b id=%0d, want 1 0", last_avail, last_id);
    end
    // Reset while traffic is outstanding and an AW is being offered.
    alloc_req_i = 1; alloc_commit_i = 0; b_done_i = 1; b_id_i = 2'd1;
    #2;
    rst_ni = 1'b0;
    #1;
    alloc_req_i = 0; b_done_i = 0;
    #1;
    check_reset_values("mid_reset");
    m_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle();
    n_vec++;
    if (busy_o !== 4'b0000 || usage_o !== 3'd0 || last_id !== 2'd0) begin
      n_err++;
      $display("FAIL after_reset: got busy=%b usage=%0d id=%0d, want 0000 0 0", busy_o, usage_o, last_id);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      logic req;
      req = m_lock ? 1'b1 : 1'($urandom_range(0, 1));
      cycle(req, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, got running, want done");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_offer_stability();
    test_need_r();
    test_same_cycle();
    test_err();
    test_avail_timing();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/floo_atop_id_allocator.md
Name: floo_atop_id_allocator

Overview:
- Allocates and tracks the unique AXI IDs that atomic (ATOP) transactions carry on the outbound side of the chimney's meta buffer.
- Owns a pool of NumIds slots and hands out the lowest free slot to an ATOP AW. The offered ID stays stable while the AW waits for downstream ready.
- A slot is retired only after every expected response has returned: the B, plus the last R beat if the ATOP has an R response.
- Replaces the ad-hoc lzc and pending logic in the meta buffer with one verifiable controller.

Parameters:
- NumIds, 4, number of atomic IDs in the pool; must be ≥ 1.
- IdWidth, cf_math_pkg::idx_width(NumIds), width of the ID output; derived, never overridden.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- alloc_req_i, in, 1, ATOP AW is valid toward downstream and needs an ID.
- alloc_need_r_i, in, 1, that ATOP expects an R response (atop[ATOP_R_RESP]); sampled at commit.
- alloc_commit_i, in, 1, downstream accepted the AW this cycle; only meaningful together with alloc_req_i && alloc_avail_o.
- alloc_avail_o, out, 1, an ID is offered; gates AW valid and ready.
- alloc_id_o, out, IdWidth, ID to drive on AW.id.
- b_done_i, in, 1, B handshake for an atomic ID.
- b_id_i, in, IdWidth, ID of that B.
- r_done_i, in, 1, R handshake with last=1 for an atomic ID.
- r_id_i, in, IdWidth, ID of that R.
- busy_o, out, NumIds, per-slot "not free" vector.
- usage_o, out, IdWidth+1, number of non-free slots.
- err_o, out, 1, single-cycle pulse on an illegal completion.

Behaviour:
- Per-slot state, 2 bits, one of four states:
  - FREE.
  - WAIT_BR: B and R outstanding.
  - WAIT_B: only B outstanding.
  - WAIT_R: only R outstanding.
- Slot transitions:
  - Commit to slot k (FREE):
    - alloc_need_r_i=1 → WAIT_BR.
    - alloc_need_r_i=0 → WAIT_B.
  - From WAIT_BR:
    - b_done for k → WAIT_R.
    - r_done for k → WAIT_B.
    - both in the same cycle → FREE.
  - WAIT_B + b_done → FREE.
  - WAIT_R + r_done → FREE.
- Illegal completions:
  - b_done to a FREE or WAIT_R slot, or r_done to a FREE or WAIT_B slot: state unchanged, err_o=1 next cycle.
  - ID ≥ NumIds: same handling.
- Offer logic:
  - free_vec is computed from registered state only. A slot freed in cycle t is offerable from t+1, never in t.
  - alloc_avail_o = |free_vec, or offer_lock_q is set.
  - offer_lock_q is set when alloc_req_i && alloc_avail_o && !alloc_commit_i; the offered ID is held in offer_id_q.
  - While offer_lock_q=1: alloc_id_o = offer_id_q and alloc_avail_o = 1, even if a lower slot frees meanwhile.
  - Otherwise alloc_id_o = lowest index in free_vec (lzc), and 0 when none is free.
  - Lock clears on commit.
  - Dropping alloc_req_i without commit is an AXI violation and is not supported; assert it.
- Commit:
  - alloc_req_i && alloc_avail_o && alloc_commit_i moves slot alloc_id_o to its WAIT state at the next edge.
  - Combinational avail → commit path, zero-cycle grant latency.
- Simultaneous events: commit on slot j plus completions on other slots in the same cycle all apply. Commit on a slot that is not FREE is impossible by construction; assert it.
- Usage counter:
  - usage_o is registered. Change per cycle = +1 for a commit, −1 for each slot entering FREE (up to 2, B and R on different slots).
  - Saturation cannot occur; assert 0 ≤ usage_o ≤ NumIds.
- Reset values: all slots FREE, offer_lock_q=0, offer_id_q=0, usage_o=0, err_o=0, busy_o=0, alloc_avail_o=1, alloc_id_o=0.
- Reset mid-operation discards all outstanding state. Upstream must not deliver stale responses after reset.
- NumIds=1: lzc is degenerate, alloc_id_o is constant 0, and IdWidth is still 1.

Decomposition:
- floo_pkg additions:
  - atop_slot_state_e (FREE, WAIT_BR, WAIT_B, WAIT_R).
  - Helper function next_slot_state(state, commit, need_r, b, r) returning the new state and an illegal flag.
- Sub-module floo_atop_slot: one instance per ID. Holds the state register and decodes b_done/r_done/commit addressed to its index; outputs free and err.
- Top level holds the lzc, the offer lock and the usage counter.

Test Plan:
- Post-reset, NumIds=4, alloc_req_i=1, commit=1 for 4 consecutive cycles, need_r=0 → IDs 0,1,2,3; alloc_avail_o=0 in cycle 5; usage_o=4.
- Offer stability: with ID 0 busy, alloc_req_i=1 and commit=0 for 3 cycles → alloc_id_o=1. b_done id0 in cycle 2 → alloc_id_o stays 1 until commit; then ID 0 is offered next.
- need_r=1 on ID 2 → after b_done id2 the slot is still busy (WAIT_R), busy_o[2]=1. After r_done id2 → busy_o[2]=0 next cycle, usage_o decrements by 1.
- Same-cycle b_done and r_done on WAIT_BR slot 1, plus commit on slot 3 → slot 1 FREE, slot 3 busy, net usage change 0.
- b_done on FREE ID 3 → err_o=1 for exactly one cycle, busy_o and usage_o unchanged.
- Slot 0 freed in cycle t while all others are busy → alloc_avail_o rises at t+1, not t. Assert rst_ni mid-traffic → all outputs at reset values.
